// File: rtl/pkg_dtypes.sv
// -----------------------------------------------------------------------------
// pkg_dtypes
// Shared data types for the execution unit.
//   type_exec_unit_addr : xbuf entry address
//   type_exec_unit_data : operand / immediate / xbuf data word
//   type_opcol_state    : operand collector FSM state, also exported on the
//                         collector's debug port
// -----------------------------------------------------------------------------
package pkg_dtypes;

  localparam int unsigned EXEC_UNIT_ADDR_W = 8;
  localparam int unsigned EXEC_UNIT_DATA_W = 32;

  typedef logic [EXEC_UNIT_ADDR_W-1:0] type_exec_unit_addr;
  typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

  typedef enum logic [1:0] {
    OPCOL_IDLE    = 2'd0,
    OPCOL_FETCH_A = 2'd1,
    OPCOL_FETCH_B = 2'd2,
    OPCOL_PRESENT = 2'd3
  } type_opcol_state;

endpackage

// File: rtl/eu_operand_collector.sv
// -----------------------------------------------------------------------------
// eu_operand_collector
// Accepts one instruction at a time, fetches operand A (and operand B unless it
// is the immediate or the same xbuf entry as A) from the xbuf, then presents
// both operands to the ALU.
//
// Optional feature macro: EU_OPCOL_WATCHDOG_EN
//   defined   : 16-bit per-fetch wait counter; timeout_o becomes sticky-high
//               once a single fetch has waited MAX_WAIT cycles. The FSM keeps
//               retrying regardless.
//   undefined : no counter, timeout_o tied low.
//
// Parameter
//   MAX_WAIT (1..65535) : watchdog limit in cycles per operand fetch
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   instr_valid_i/ready_o   : instruction issue handshake
//   instr_opa/opb_addr_i    : operand xbuf addresses
//   instr_opb_is_imm_i      : operand B is the immediate
//   instr_imm_i             : immediate value
//   req_addr_o, req_valid_o : xbuf request
//   resp_data_i,
//   resp_success_i          : xbuf response, same cycle as the request
//   alu_opa_o, alu_opb_o    : collected operands
//   alu_valid_o/alu_ready_i : ALU handshake
//   timeout_o               : sticky watchdog flag
//   dbg_state_o             : current FSM state (observability only)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A valid source holds valid and its payload unchanged until
// that edge. Here instr_ready_o is high only in IDLE, and alu_valid_o plus the
// operands stay put in PRESENT until alu_ready_i is sampled high.
// The xbuf request has no ready: resp_success_i in the request cycle says
// whether the entry was delivered (and consumed); otherwise we re-request.
// -----------------------------------------------------------------------------
module eu_operand_collector
  import pkg_dtypes::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  type_exec_unit_addr instr_opa_addr_i,
  input  type_exec_unit_addr instr_opb_addr_i,
  input  logic               instr_opb_is_imm_i,
  input  type_exec_unit_data instr_imm_i,
  output type_exec_unit_addr req_addr_o,
  output logic               req_valid_o,
  input  type_exec_unit_data resp_data_i,
  input  logic               resp_success_i,
  output type_exec_unit_data alu_opa_o,
  output type_exec_unit_data alu_opb_o,
  output logic               alu_valid_o,
  input  logic               alu_ready_i,
  output logic               timeout_o,
  output type_opcol_state    dbg_state_o
);

  if ((MAX_WAIT < 1) || (MAX_WAIT > 65535)) begin : g_bad_max_wait
    $error("eu_operand_collector: MAX_WAIT must be in 1..65535");
  end

  type_opcol_state    state_q, state_d;
  type_exec_unit_addr opa_addr_q, opa_addr_d;
  type_exec_unit_addr opb_addr_q, opb_addr_d;
  logic               opb_is_imm_q, opb_is_imm_d;
  type_exec_unit_data imm_q, imm_d;
  type_exec_unit_data opa_q, opa_d;
  type_exec_unit_data opb_q, opb_d;
  type_exec_unit_addr req_addr_q, req_addr_d;
  // Low during reset and for the first cycle after release, so that
  // instr_ready_o only rises after the first clock edge out of reset.
  logic               active_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= OPCOL_IDLE;
      opa_addr_q   <= '0;
      opb_addr_q   <= '0;
      opb_is_imm_q <= 1'b0;
      imm_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      req_addr_q   <= '0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa_addr_q   <= opa_addr_d;
      opb_addr_q   <= opb_addr_d;
      opb_is_imm_q <= opb_is_imm_d;
      imm_q        <= imm_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      req_addr_q   <= req_addr_d;
      active_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    opa_addr_d   = opa_addr_q;
    opb_addr_d   = opb_addr_q;
    opb_is_imm_d = opb_is_imm_q;
    imm_d        = imm_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    req_addr_d   = req_addr_q;

    unique case (state_q)
      OPCOL_IDLE: begin
        if (instr_valid_i && active_q) begin
          opa_addr_d   = instr_opa_addr_i;
          opb_addr_d   = instr_opb_addr_i;
          opb_is_imm_d = instr_opb_is_imm_i;
          imm_d        = instr_imm_i;
          // The request address is a register so it holds its last value
          // while no request is outstanding.
          req_addr_d   = instr_opa_addr_i;
          state_d      = OPCOL_FETCH_A;
        end
      end

      OPCOL_FETCH_A: begin
        if (resp_success_i) begin
          opa_d = resp_data_i;
          if (opb_is_imm_q) begin
            opb_d   = imm_q;
            state_d = OPCOL_PRESENT;
          end else if (opa_addr_q == opb_addr_q) begin
            // The xbuf consumes an entry on read; reuse A instead of
            // reading the same entry a second time.
            opb_d   = resp_data_i;
            state_d = OPCOL_PRESENT;
          end else begin
            req_addr_d = opb_addr_q;
            state_d    = OPCOL_FETCH_B;
          end
        end
      end

      OPCOL_FETCH_B: begin
        if (resp_success_i) begin
          opb_d   = resp_data_i;
          state_d = OPCOL_PRESENT;
        end
      end

      OPCOL_PRESENT: begin
        if (alu_ready_i) begin
          state_d = OPCOL_IDLE;
        end
      end

      default: begin
        state_d = OPCOL_IDLE;
      end
    endcase
  end

  assign instr_ready_o = (state_q == OPCOL_IDLE) && active_q;
  assign req_valid_o   = (state_q == OPCOL_FETCH_A) || (state_q == OPCOL_FETCH_B);
  assign req_addr_o    = req_addr_q;
  assign alu_valid_o   = (state_q == OPCOL_PRESENT);
  assign alu_opa_o     = opa_q;
  assign alu_opb_o     = opb_q;
  assign dbg_state_o   = state_q;

`ifdef EU_OPCOL_WATCHDOG_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [16:0] wait_cnt_inc;
  logic        timeout_q, timeout_d;
  logic        fetching;
  logic        entering_fetch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    fetching       = (state_q == OPCOL_FETCH_A) || (state_q == OPCOL_FETCH_B);
    entering_fetch = (state_d != state_q) &&
                     ((state_d == OPCOL_FETCH_A) || (state_d == OPCOL_FETCH_B));
    wait_cnt_inc   = {1'b0, wait_cnt_q} + 17'd1;
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
    if (entering_fetch) begin
      wait_cnt_d = '0;
    end else if (fetching && !resp_success_i) begin
      // Saturate instead of wrapping so a long stall never looks short.
      if (!wait_cnt_inc[16]) begin
        wait_cnt_d = wait_cnt_inc[15:0];
      end
      if (32'(wait_cnt_inc) >= MAX_WAIT) begin
        timeout_d = 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
